// File: rtl/bf16_log.sv
// Pipelined bfloat16 natural log: capture, decode, accumulate (Q8.16), normalize.
// Define LOG_RNE_EN for round-to-nearest-even normalization; default truncates.
module bf16_log (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] data_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] data_o
);

  localparam logic [15:0] QNAN    = 16'h7FC0;
  localparam logic [15:0] NEG_INF = 16'hFF80;
  localparam logic [15:0] POS_INF = 16'h7F80;

  function automatic logic [15:0] base_lut(input logic [3:0] i);
    case (i)
      4'd0:    base_lut = 16'd0;
      4'd1:    base_lut = 16'd7719;
      4'd2:    base_lut = 16'd14624;
      4'd3:    base_lut = 16'd20870;
      4'd4:    base_lut = 16'd26573;
      4'd5:    base_lut = 16'd31818;
      4'd6:    base_lut = 16'd36675;
      4'd7:    base_lut = 16'd41196;
      default: base_lut = 16'd45426;
    endcase
  endfunction

  logic en;

  // stage 0: input capture
  logic        v0_q, v0_d;
  logic [15:0] x0_q, x0_d;
  // stage 1: decode
  logic        v1_q, v1_d;
  logic signed [8:0] exp1_q, exp1_d;
  logic [2:0]  idx1_q, idx1_d;
  logic [3:0]  frac1_q, frac1_d;
  logic        ovr_en1_q, ovr_en1_d;
  logic [15:0] ovr1_q, ovr1_d;
  // stage 2: accumulate
  logic        v2_q, v2_d;
  logic signed [24:0] sum2_q, sum2_d;
  logic        ovr_en2_q, ovr_en2_d;
  logic [15:0] ovr2_q, ovr2_d;
  // stage 3: output
  logic        out_valid_q, out_valid_d;
  logic [15:0] data_o_q, data_o_d;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign data_o    = data_o_q;

  always_comb begin
    v0_d = in_valid;
    x0_d = data_i;
  end

  always_comb begin
    logic       s;
    logic [7:0] e;
    logic [6:0] m;
    s = x0_q[15];
    e = x0_q[14:7];
    m = x0_q[6:0];
    v1_d      = v0_q;
    exp1_d    = $signed({1'b0, e} - 9'd127);
    idx1_d    = m[6:4];
    frac1_d   = m[3:0];
    ovr_en1_d = 1'b1;
    ovr1_d    = '0;
    if (e == 8'd0)                     ovr1_d = NEG_INF;
    else if (e == 8'hFF && m != 7'd0)  ovr1_d = QNAN;
    else if (s)                        ovr1_d = QNAN;
    else if (e == 8'hFF)               ovr1_d = POS_INF;
    else                               ovr_en1_d = 1'b0;
  end

  always_comb begin
    logic [15:0] base;
    logic [15:0] slope;
    logic [15:0] lnm;
    logic signed [24:0] e_ext;
    base  = base_lut({1'b0, idx1_q});
    slope = base_lut({1'b0, idx1_q} + 4'd1) - base;
    lnm   = base + 16'((17'(slope) * 17'(frac1_q)) >> 4);
    e_ext = {{16{exp1_q[8]}}, exp1_q};
    v2_d      = v1_q;
    sum2_d    = e_ext * 25'sd45426 + $signed({9'd0, lnm});
    ovr_en2_d = ovr_en1_q;
    ovr2_d    = ovr1_q;
  end

  always_comb begin
    logic        neg;
    logic [23:0] mag;
    logic [4:0]  lead;
    logic [4:0]  sh;
    logic [6:0]  mant;
    logic [7:0]  expf;
    logic        round_up;
    neg  = sum2_q[24];
    mag  = neg ? 24'(-sum2_q) : 24'(sum2_q);
    lead = '0;
    for (int unsigned i = 0; i < 24; i++) begin
      if (mag[i]) lead = 5'(i);
    end
    sh       = 5'd23 - lead;
    mant     = 7'((mag << sh) >> 16);
    expf     = 8'd111 + {3'd0, lead};
    round_up = 1'b0;
`ifdef LOG_RNE_EN
    begin
      logic [15:0] low;
      low      = 16'(mag << sh);
      round_up = low[15] & ((|low[14:0]) | mant[0]);
    end
`endif
    if (round_up) begin
      // all-ones mantissa wraps to zero and bumps the exponent
      if (mant == 7'h7F) expf = expf + 8'd1;
      mant = mant + 7'd1;
    end
    out_valid_d = v2_q;
    data_o_d    = data_o_q;
    if (v2_q) begin
      if (ovr_en2_q)         data_o_d = ovr2_q;
      else if (mag == 24'd0) data_o_d = '0;
      else                   data_o_d = {neg, expf, mant};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      data_o_q    <= '0;
    end else if (en) begin
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      out_valid_q <= out_valid_d;
      data_o_q    <= data_o_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      x0_q      <= x0_d;
      exp1_q    <= exp1_d;
      idx1_q    <= idx1_d;
      frac1_q   <= frac1_d;
      ovr_en1_q <= ovr_en1_d;
      ovr1_q    <= ovr1_d;
      sum2_q    <= sum2_d;
      ovr_en2_q <= ovr_en2_d;
      ovr2_q    <= ovr2_d;
    end
  end

endmodule

// File: tb/tb_bf16_log.sv
// Self-checking bench for bf16_log: fixed vectors, specials, backpressure,
// reset mid-stream and a full 16-bit sweep against a Q8.16 reference model.
module tb_bf16_log;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] data_i = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] data_o;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [15:0] sb[$];
  int base_tab[9] = '{0, 7719, 14624, 20870, 26573, 31818, 36675, 41196, 45426};

  always #5 clk = ~clk;

  bf16_log dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_i   (data_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_o   (data_o)
  );

  function automatic logic [15:0] ref_log(input logic [15:0] x);
    int e, m, idx, f, lnm, s, mag, p, mant, ex;
    longint full;
    bit neg;
    e = int'(x[14:7]);
    m = int'(x[6:0]);
    if (e == 0) return 16'hFF80;
    if (e == 255 && m != 0) return 16'h7FC0;
    if (x[15]) return 16'h7FC0;
    if (e == 255) return 16'h7F80;
    idx = m / 16;
    f   = m % 16;
    lnm = base_tab[idx] + ((base_tab[idx+1] - base_tab[idx]) * f) / 16;
    s   = (e - 127) * 45426 + lnm;
    neg = (s < 0);
    mag = neg ? -s : s;
    if (mag == 0) return 16'h0000;
    p = 0;
    while (mag >= (1 << (p + 1))) p++;
    full = (longint'(mag) << 24) >> p;
    mant = int'((full >> 17) & 127);
    ex   = 111 + p;
`ifdef LOG_RNE_EN
    if (((full >> 16) & 1) == 1 && ((full & 65535) != 0 || (mant % 2) == 1)) begin
      mant = mant + 1;
      if (mant == 128) begin
        mant = 0;
        ex   = ex + 1;
      end
    end
`endif
    return {neg, 8'(ex), 7'(mant)};
  endfunction

  // drive one cycle's inputs at negedge, sample DUT just after
  task automatic cycle(input logic r, input logic v, input logic [15:0] d, input logic ordy,
                       output logic ov, output logic [15:0] dq, output logic ir);
    @(negedge clk);
    rst = r; in_valid = v; data_i = d; out_ready = ordy;
    #1;
    ov = out_valid; dq = data_o; ir = in_ready;
  endtask

  task automatic test_reset();
    logic ov, ir; logic [15:0] dq;
    cycle(1'b1, 1'b0, 16'h0, 1'b1, ov, dq, ir);
    cycle(1'b0, 1'b0, 16'h0, 1'b1, ov, dq, ir);
    n_total++; if (ov !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", ov); else n_pass++;
    n_total++; if (dq !== 16'h0000) $display("FAIL reset_data_o: got %h expected 0000", dq); else n_pass++;
    n_total++; if (ir !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", ir); else n_pass++;
  endtask

  task automatic test_basic();
    logic [15:0] vin[3] = '{16'h3F80, 16'h4000, 16'h3F00};
    logic [15:0] vex[3] = '{16'h0000, 16'h3F31, 16'hBF31};
    logic ov, ir; logic [15:0] dq, got;
    int lat;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, vin[k], 1'b1, ov, dq, ir);
      n_total++; if (ir !== 1'b1) $display("FAIL basic_accept: got %b expected 1", ir); else n_pass++;
      lat = 0; got = '0;
      for (int c = 1; c <= 6; c++) begin
        cycle(1'b0, 1'b0, 16'h0, 1'b1, ov, dq, ir);
        if (ov === 1'b1 && lat == 0) begin lat = c; got = dq; end
      end
      n_total++; if (lat != 4) $display("FAIL basic_latency %h: got sample %0d expected 4", vin[k], lat); else n_pass++;
      n_total++; if (got !== vex[k]) $display("FAIL basic_value %h: got %h expected %h", vin[k], got, vex[k]); else n_pass++;
    end
  endtask

  task automatic test_specials();
    logic [15:0] vin[7] = '{16'h0000, 16'h8000, 16'h0001, 16'hBF80, 16'h7F80, 16'h7FC1, 16'hFF80};
    logic [15:0] vex[7] = '{16'hFF80, 16'hFF80, 16'hFF80, 16'h7FC0, 16'h7F80, 16'h7FC0, 16'h7FC0};
    logic ov, ir, v; logic [15:0] dq, d, exp_v;
    int sent = 0, got = 0;
    sb.delete();
    for (int c = 0; c < 40 && got < 7; c++) begin
      v = (sent < 7);
      d = v ? vin[sent] : 16'h0;
      cycle(1'b0, v, d, 1'b1, ov, dq, ir);
      if (v && ir) begin sb.push_back(vex[sent]); sent++; end
      if (ov) begin
        if (sb.size() == 0) begin
          n_total++; $display("FAIL special_extra: got %h expected no output", dq);
        end else begin
          exp_v = sb.pop_front();
          n_total++; if (dq !== exp_v) $display("FAIL special_value: got %h expected %h", dq, exp_v); else n_pass++;
        end
        got++;
      end
    end
    n_total++; if (got != 7) $display("FAIL special_count: got %0d expected 7", got); else n_pass++;
  endtask

  task automatic test_rounding();
    logic ov, ir; logic [15:0] dq, got, exp_v;
    int lat;
`ifdef LOG_RNE_EN
    exp_v = 16'h3F80;
`else
    exp_v = 16'h3F7F;
`endif
    cycle(1'b0, 1'b1, 16'h402E, 1'b1, ov, dq, ir);
    lat = 0; got = '0;
    for (int c = 1; c <= 6; c++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b1, ov, dq, ir);
      if (ov === 1'b1 && lat == 0) begin lat = c; got = dq; end
    end
    n_total++; if (lat != 4 || got !== exp_v)
      $display("FAIL round_402E: got %h at sample %0d expected %h at sample 4", got, lat, exp_v);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [15:0] ops[8];
    logic ov, ir, v, ordy, prev_stall; logic [15:0] dq, d, prev_d, exp_v;
    int sent = 0, got = 0;
    for (int i = 0; i < 8; i++) ops[i] = {1'b0, 8'($urandom_range(90, 170)), 7'($urandom_range(0, 127))};
    sb.delete();
    prev_stall = 1'b0; prev_d = '0;
    for (int c = 0; c < 300 && got < 8; c++) begin
      v    = (sent < 8);
      d    = v ? ops[sent] : 16'h0;
      ordy = 1'($urandom_range(0, 1));
      cycle(1'b0, v, d, ordy, ov, dq, ir);
      n_total++; if (ir !== (!ov || ordy)) $display("FAIL bp_in_ready: got %b expected %b", ir, (!ov || ordy)); else n_pass++;
      if (prev_stall) begin
        n_total++; if (dq !== prev_d) $display("FAIL bp_stable: got %h expected %h", dq, prev_d); else n_pass++;
      end
      if (v && ir) begin sb.push_back(ref_log(d)); sent++; end
      if (ov && ordy) begin
        if (sb.size() == 0) begin
          n_total++; $display("FAIL bp_extra: got %h expected no output", dq);
        end else begin
          exp_v = sb.pop_front();
          n_total++; if (dq !== exp_v) $display("FAIL bp_value: got %h expected %h", dq, exp_v); else n_pass++;
        end
        got++;
      end
      prev_stall = ov && !ordy;
      prev_d     = dq;
    end
    n_total++; if (got != 8 || sb.size() != 0)
      $display("FAIL bp_count: got %0d outputs expected 8 (left %0d)", got, sb.size());
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    logic ov, ir; logic [15:0] dq, got;
    int lat, stale;
    cycle(1'b0, 1'b1, 16'h4100, 1'b1, ov, dq, ir);
    cycle(1'b0, 1'b1, 16'h3E00, 1'b1, ov, dq, ir);
    cycle(1'b0, 1'b1, 16'h4280, 1'b1, ov, dq, ir);
    cycle(1'b1, 1'b1, 16'h4000, 1'b1, ov, dq, ir);
    cycle(1'b0, 1'b0, 16'h0, 1'b1, ov, dq, ir);
    n_total++; if (ov !== 1'b0) $display("FAIL mid_rst_valid: got %b expected 0", ov); else n_pass++;
    n_total++; if (dq !== 16'h0000) $display("FAIL mid_rst_data: got %h expected 0000", dq); else n_pass++;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b1, ov, dq, ir);
      if (ov !== 1'b0) stale++;
    end
    n_total++; if (stale != 0) $display("FAIL mid_rst_stale: got %0d outputs expected 0", stale); else n_pass++;
    cycle(1'b0, 1'b1, 16'h4000, 1'b1, ov, dq, ir);
    lat = 0; got = '0;
    for (int c = 1; c <= 6; c++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b1, ov, dq, ir);
      if (ov === 1'b1 && lat == 0) begin lat = c; got = dq; end
    end
    n_total++; if (lat != 4 || got !== 16'h3F31)
      $display("FAIL mid_rst_resume: got %h at sample %0d expected 3f31 at sample 4", got, lat);
    else n_pass++;
  endtask

  task automatic test_sweep();
    logic ov, ir, v; logic [15:0] dq, d, exp_v;
    int sent = 0, got = 0, bad = 0;
    sb.delete();
    for (int c = 0; c < 65600 && got < 65536; c++) begin
      v = (sent < 65536);
      d = 16'(sent);
      cycle(1'b0, v, d, 1'b1, ov, dq, ir);
      if (v && ir) begin sb.push_back(ref_log(d)); sent++; end
      if (ov) begin
        if (sb.size() == 0) begin
          n_total++; $display("FAIL sweep_extra: got %h expected no output", dq);
        end else begin
          exp_v = sb.pop_front();
          n_total++;
          if (dq !== exp_v) begin
            if (bad < 20) $display("FAIL sweep_value #%0d: got %h expected %h", got, dq, exp_v);
            bad++;
          end else n_pass++;
        end
        got++;
      end
    end
    n_total++; if (got != 65536) $display("FAIL sweep_count: got %0d expected 65536", got); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_specials();
    test_rounding();
    test_backpressure();
    test_reset_midstream();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
